pipe_scheduler: RTL and testbench
=================================

// Module: pipe_scheduler
// PURPOSE
//  Sequencer for the scrolling pipe field (16x16 pipefield shift register).
//  Generates the one-cycle shift strobe clkP and the column pattern newPipe.
//  Pipe gap positions come from an internal LFSR. Scroll speed ramps up as pipes are emitted.
//  Sits between the game FSM (start/gameover) and the pipe field.
// PARAMETERS
//  ROWS        16     field height; width of newPipe
//  GAP         4      gap height in rows (zeros in a pipe column)
//  SPACING     4      shifts per pipe period: 1 pipe column + SPACING-1 empty columns
//  PERIOD_INIT 48     ticks per shift after start
//  PERIOD_MIN  16     floor for the shift period
//  PERIOD_STEP 4      period decrement per ramp step
//  RAMP_PIPES  8      pipes emitted per ramp step
//  LFSR_SEED   8'hA5  LFSR value after reset/start; must be nonzero
// PORTS
//  clk        in   1     system clock
//  reset      in   1     synchronous, active-high
//  start      in   1     level; begins or restarts a run
//  gameover   in   1     level; freezes scheduling
//  tick       in   1     one-cycle frame-rate enable
//  clkP       out  1     shift strobe to pipe field, one clk wide
//  newPipe    out  ROWS  column to insert; bit i = row i; 1 = pipe
//  pipe_count out  8     pipes emitted this run, saturates at 255
//  period     out  8     current ticks-per-shift
//  running    out  1     1 while in RUN
// BEHAVIOUR
//  Register contents
//   - All outputs are registered.
//   - Reset (sync, any state, priority over all inputs) gives:
//     state=IDLE, clkP=0, newPipe=0, pipe_count=0, running=0, period=PERIOD_INIT,
//     tick_cnt=0, col_cnt=0, ramp_cnt=0, lfsr=LFSR_SEED.
//  FSM states IDLE / RUN / OVER
//   - IDLE: start && !gameover -> RUN. On that edge, reinit every counter, period and lfsr
//     to the reset values. Otherwise stay in IDLE with clkP=0.
//   - RUN: running=1.
//     - Each tick increments tick_cnt.
//     - On a tick with tick_cnt==period-1: tick_cnt<=0, clkP<=1 for exactly one cycle,
//       newPipe<=column. clkP is 0 on every other cycle.
//     - col_cnt==0 -> column = all ones except rows gap_top..gap_top+GAP-1 = 0.
//       Also: lfsr advances one step, pipe_count++ (saturating), ramp_cnt++.
//     - col_cnt!=0 -> column = 0.
//     - col_cnt increments mod SPACING on every shift.
//     - newPipe holds its value between shifts and is stable whenever clkP=1.
//     - First shift after start emits a pipe.
//  Gap position
//   - gap_top = lfsr[3:0], minus (ROWS-GAP+1) if it exceeds ROWS-GAP.
//     Range 0..ROWS-GAP; the gap never clips the field.
//  LFSR
//   - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts toward the MSB.
//  Speed ramp
//   - When ramp_cnt reaches RAMP_PIPES: ramp_cnt<=0, period<=max(period-PERIOD_STEP, PERIOD_MIN).
//   - The new period takes effect from the next shift interval.
//  gameover
//   - gameover in RUN -> OVER. No clkP is produced on or after the edge that samples it,
//     even if that same edge completes a period.
//  OVER state
//   - clkP=0, running=0. newPipe, pipe_count and period hold their values.
//   - start && !gameover -> RUN with full reinit; otherwise stay in OVER.
//  Conflicts and boundaries
//   - start && gameover together: gameover wins; no state change out of IDLE/OVER.
//   - tick while not in RUN is ignored.
//   - start while in RUN is ignored.
//  Timing
//   - With tick held at 1, clkP first asserts PERIOD_INIT cycles after the edge that samples start.
// TESTING
//  1. reset=1 2 cycles with start=1 -> clkP=0, newPipe=0, period=48, running=0.
//  2. start pulse, tick=1 constant -> clkP high 1 cycle at +48 cycles.
//     newPipe=16'hFE1F (gap rows 5..8 from seed A5). Next 3 shifts: newPipe=0.
//     5th shift: a pipe again.
//  3. Run 8 pipes (32 shifts) -> pipe_count=8, period=44. Next shift spacing = 44 ticks.
//     Continue ramping: period floors at 16, never 12.
//  4. gameover=1 on the edge where tick_cnt==period-1 -> no clkP, state OVER.
//     newPipe and pipe_count unchanged for 100 cycles.
//  5. start=1 && gameover=1 in OVER -> stays OVER.
//     Drop gameover, start=1 -> RUN, pipe_count=0, period=48, first pipe again 16'hFE1F.
//  6. tick toggled every 3rd cycle in RUN; reset=1 mid-run -> IDLE next edge, all reset values.
//     Check each gap_top over 64 pipes lies in 0..12.

Source files
------------

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - scroll sequencer: shift strobe, LFSR-gapped pipe columns, speed ramp
module pipe_scheduler #(
    parameter int         ROWS        = 16,
    parameter int         GAP         = 4,
    parameter int         SPACING     = 4,
    parameter int         PERIOD_INIT = 48,
    parameter int         PERIOD_MIN  = 16,
    parameter int         PERIOD_STEP = 4,
    parameter int         RAMP_PIPES  = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            gameover,
    input  logic            tick,
    output logic            clkP,
    output logic [ROWS-1:0] newPipe,
    output logic [7:0]      pipe_count,
    output logic [7:0]      period,
    output logic            running
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] OVER = 2'd2;

    localparam logic [7:0] P_INIT   = 8'(PERIOD_INIT);
    localparam logic [7:0] P_MIN    = 8'(PERIOD_MIN);
    localparam logic [7:0] P_STEP   = 8'(PERIOD_STEP);
    localparam logic [7:0] COL_LAST = 8'(SPACING - 1);
    localparam logic [7:0] RAMP_LAST = 8'(RAMP_PIPES - 1);
    localparam int         MAX_TOP  = ROWS - GAP;

    logic [1:0]      state;
    logic [7:0]      tickCnt;
    logic [7:0]      colCnt;
    logic [7:0]      rampCnt;
    logic [7:0]      lfsr;
    logic [7:0]      lfsrNext;
    logic [7:0]      periodNext;
    int              gapTop;
    logic [ROWS-1:0] pipeCol;

    assign lfsrNext   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign periodNext = (period >= P_MIN + P_STEP) ? period - P_STEP : P_MIN;

    // Folding the raw nibble back keeps the whole gap inside the field.
    always_comb begin
        gapTop = int'(lfsr[3:0]);
        if (gapTop > MAX_TOP)
            gapTop = gapTop - (MAX_TOP + 1);
        pipeCol = '1;
        for (int i = 0; i < ROWS; i++) begin
            if (i >= gapTop && i < gapTop + GAP)
                pipeCol[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clkP       <= 1'b0;
            newPipe    <= '0;
            pipe_count <= 8'd0;
            running    <= 1'b0;
            period     <= P_INIT;
            tickCnt    <= 8'd0;
            colCnt     <= 8'd0;
            rampCnt    <= 8'd0;
            lfsr       <= LFSR_SEED;
        end else begin
            clkP <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start && !gameover) begin
                        state      <= RUN;
                        running    <= 1'b1;
                        pipe_count <= 8'd0;
                        period     <= P_INIT;
                        tickCnt    <= 8'd0;
                        colCnt     <= 8'd0;
                        rampCnt    <= 8'd0;
                        lfsr       <= LFSR_SEED;
                    end
                end
                RUN: begin
                    // gameover is checked first so a completing period cannot still strobe.
                    if (gameover) begin
                        state   <= OVER;
                        running <= 1'b0;
                    end else if (tick) begin
                        if (tickCnt == period - 8'd1) begin
                            tickCnt <= 8'd0;
                            clkP    <= 1'b1;
                            colCnt  <= (colCnt == COL_LAST) ? 8'd0 : colCnt + 8'd1;
                            if (colCnt == 8'd0) begin
                                newPipe <= pipeCol;
                                lfsr    <= lfsrNext;
                                if (pipe_count != 8'd255)
                                    pipe_count <= pipe_count + 8'd1;
                                if (rampCnt == RAMP_LAST) begin
                                    rampCnt <= 8'd0;
                                    period  <= periodNext;
                                end else begin
                                    rampCnt <= rampCnt + 8'd1;
                                end
                            end else begin
                                newPipe <= '0;
                            end
                        end else begin
                            tickCnt <= tickCnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - self-checking bench for pipe_scheduler against a behavioural model
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        reset, start, gameover, tick;
    logic        clkP;
    logic [15:0] newPipe;
    logic [7:0]  pipe_count, period;
    logic        running;

    int checks = 0;
    int errors = 0;
    bit checkOn = 0;
    int gapPipes = 0;

    pipe_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .gameover(gameover), .tick(tick),
        .clkP(clkP), .newPipe(newPipe), .pipe_count(pipe_count), .period(period),
        .running(running)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: run status, ticks since last shift, shifts and pipes this run, LFSR value.
    int          mState = 0;
    int          mTicks, mShifts, mPipes;
    logic [7:0]  mLfsr;
    bit          mClkP;
    logic [15:0] mCol;

    function automatic int speedFor(input int pipes);
        int p;
        p = 48 - 4 * (pipes / 8);
        return (p < 16) ? 16 : p;
    endfunction

    function automatic logic [7:0] lfsrStep(input logic [7:0] x);
        return {x[6:0], ^(x & 8'hB8)};
    endfunction

    function automatic logic [15:0] pipeFor(input logic [7:0] l);
        int g;
        logic [15:0] ones;
        g = l % 16;
        if (g > 12) g = g - 13;
        ones = 16'hFFFF;
        return ones ^ (16'h000F << g);
    endfunction

    task automatic modelStep();
        mClkP = 0;
        if (reset) begin
            mState = 0; mTicks = 0; mShifts = 0; mPipes = 0; mLfsr = 8'hA5; mCol = 16'h0;
        end else if (mState != 1) begin
            if (start && !gameover) begin
                mState = 1; mTicks = 0; mShifts = 0; mPipes = 0; mLfsr = 8'hA5;
            end
        end else if (gameover) begin
            mState = 2;
        end else if (tick) begin
            if (mTicks + 1 == speedFor(mPipes)) begin
                mTicks = 0;
                mClkP  = 1;
                if (mShifts % 4 == 0) begin
                    mCol   = pipeFor(mLfsr);
                    mLfsr  = lfsrStep(mLfsr);
                    mPipes = mPipes + 1;
                end else begin
                    mCol = 16'h0;
                end
                mShifts = mShifts + 1;
            end else begin
                mTicks = mTicks + 1;
            end
        end
    endtask

    always @(posedge clk) begin
        int g;
        modelStep();
        #1;
        if (checkOn) begin
            chk("clkP", clkP, mClkP);
            chk("running", running, mState == 1);
            chk("newPipe", newPipe, mCol);
            chk("pipe_count", pipe_count, (mPipes > 255) ? 255 : mPipes);
            chk("period", period, speedFor(mPipes));
            if (clkP && newPipe != 16'h0) begin
                g = 0;
                while (g < 16 && newPipe[g]) g++;
                chk("gap_range", g <= 12, 1);
                gapPipes++;
            end
        end
    end

    task automatic waitShift(output int n, input int bound);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!clkP && n < bound);
        if (!clkP) chk("shift_timeout", 0, 1);
    endtask

    initial begin
        int n, minP, seen;
        logic [15:0] np;
        logic [7:0]  pc;
        reset = 1; start = 1; gameover = 0; tick = 0;
        @(negedge clk);
        checkOn = 1;
        @(negedge clk);
        chk("rst_clkP", clkP, 0);
        chk("rst_newPipe", newPipe, 16'h0);
        chk("rst_period", period, 48);
        chk("rst_running", running, 0);
        reset = 0; start = 0;
        repeat (3) @(negedge clk);

        // First run: latency, first column and pipe spacing.
        tick = 1; start = 1;
        @(negedge clk);
        start = 0;
        waitShift(n, 200);
        chk("first_latency", n, 48);
        chk("first_pipe", newPipe, 16'hFE1F);
        for (int s = 2; s <= 4; s++) begin
            waitShift(n, 200);
            chk("empty_col", newPipe, 16'h0);
        end
        waitShift(n, 200);
        chk("shift5_pipe", newPipe != 16'h0, 1);

        // Ramp: after 32 shifts, 8 pipes and period 44; then floor at 16.
        for (int s = 6; s <= 32; s++) waitShift(n, 200);
        chk("ramp_pipes", pipe_count, 8);
        chk("ramp_period", period, 44);
        waitShift(n, 200);
        chk("ramp_spacing", n, 44);
        minP = 255;
        for (int s = 0; s < 300; s++) begin
            waitShift(n, 200);
            if (period < minP) minP = period;
        end
        chk("floor_period", period, 16);
        chk("floor_min", minP, 16);
        waitShift(n, 200);
        chk("floor_spacing", n, 16);

        // gameover on the edge that would complete a period.
        n = 0;
        while (!(mTicks == speedFor(mPipes) - 1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("go_align", mTicks, speedFor(mPipes) - 1);
        np = newPipe; pc = pipe_count;
        gameover = 1;
        @(negedge clk);
        chk("go_clkP", clkP, 0);
        chk("go_running", running, 0);
        gameover = 0;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (clkP) seen++;
        end
        chk("over_noshift", seen, 0);
        chk("over_newPipe", newPipe, np);
        chk("over_count", pipe_count, pc);

        // start with gameover stays in OVER; clean start restarts.
        start = 1; gameover = 1;
        repeat (3) @(negedge clk);
        chk("conflict_running", running, 0);
        gameover = 0;
        @(negedge clk);
        start = 0;
        chk("restart_running", running, 1);
        chk("restart_count", pipe_count, 0);
        chk("restart_period", period, 48);
        waitShift(n, 200);
        chk("restart_latency", n, 48);
        chk("restart_pipe", newPipe, 16'hFE1F);

        // Random sparse ticks until 64 pipes, then reset mid-run.
        gapPipes = 0;
        n = 0;
        while (gapPipes < 64 && n < 60000) begin
            @(negedge clk);
            tick = ($urandom_range(0, 2) == 0);
            n++;
        end
        chk("gap_pipes", gapPipes >= 64, 1);
        chk("pre_reset_running", running, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_rst_running", running, 0);
        chk("mid_rst_clkP", clkP, 0);
        chk("mid_rst_newPipe", newPipe, 16'h0);
        chk("mid_rst_count", pipe_count, 0);
        chk("mid_rst_period", period, 48);

        // Random control mix, checked cycle by cycle against the model.
        repeat (4000) begin
            @(negedge clk);
            tick     = ($urandom_range(0, 2) == 0);
            start    = ($urandom_range(0, 49) == 0);
            gameover = ($urandom_range(0, 299) == 0);
            reset    = ($urandom_range(0, 1499) == 0);
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
